// File: rtl/code_serializer.sv
// Parallel-to-serial feeder for the sequence detector: a valid/ready word in, one bit per clock out,
// with GAP zero cycles between words. Define CODE_SER_LSB_FIRST_EN for LSB-first order (MSB-first otherwise).
module code_serializer #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_valid,
  output logic             code_ready,
  output logic             data_out,
  output logic             bit_valid,
  output logic             bit_last
);

  localparam int MAX_WG = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CNT_W  = $clog2((MAX_WG > 2) ? MAX_WG : 2);
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_gap_cnt;
  logic             r_data_out;
  logic             r_bit_valid;

  logic             w_accept;
  logic             w_load_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_next_rest;

  // The shift register holds only the bits not yet emitted, aligned so the next one sits at the exit end.
`ifdef CODE_SER_LSB_FIRST_EN
  assign w_load_bit  = code_in[0];
  assign w_load_rest = code_in >> 1;
  assign w_next_bit  = r_shift[0];
  assign w_next_rest = r_shift >> 1;
`else
  assign w_load_bit  = code_in[WIDTH-1];
  assign w_load_rest = code_in << 1;
  assign w_next_bit  = r_shift[WIDTH-1];
  assign w_next_rest = r_shift << 1;
`endif

  // NOTE: code_ready looks only at state and rst_n, never at code_valid, so no combinational loop can form through the producer.
  always_comb begin
    code_ready = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE:  code_ready = 1'b1;
        S_SHIFT: code_ready = (r_bit_cnt == '0) && (GAP == 0);
        S_GAP:   code_ready = (r_gap_cnt == '0);
        default: code_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = code_valid && code_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_data_out  <= 1'b0;
      r_bit_valid <= 1'b0;
    end else if (w_accept) begin
      // Ready is only raised in the cycles where a new word may start, so one load path serves all states.
      r_state     <= S_SHIFT;
      r_shift     <= w_load_rest;
      r_bit_cnt   <= BIT_LOAD;
      r_gap_cnt   <= '0;
      r_data_out  <= w_load_bit;
      r_bit_valid <= 1'b1;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (r_bit_cnt != '0) begin
            r_data_out <= w_next_bit;
            r_shift    <= w_next_rest;
            r_bit_cnt  <= r_bit_cnt - CNT_W'(1);
          end else begin
            r_data_out  <= 1'b0;
            r_bit_valid <= 1'b0;
            if (GAP > 0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          r_data_out  <= 1'b0;
          r_bit_valid <= 1'b0;
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - CNT_W'(1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_data_out  <= 1'b0;
          r_bit_valid <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign bit_valid = r_bit_valid;
  assign bit_last  = r_bit_valid && (r_bit_cnt == '0);

endmodule

// File: tb/tb_code_serializer.sv
// Scoreboard bench for code_serializer: two instances (GAP=1 and GAP=0) share one clock, each with
// its own driver, cycle-level expectation queue and monitor.
module tb_code_serializer;

  localparam int W = 4;

  typedef struct packed {
    logic d;
    logic v;
    logic l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit done [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int GP = (g == 0) ? 1 : 0;

    logic         rst_n      = 1'b0;
    logic         code_valid = 1'b0;
    logic [W-1:0] code_in    = '0;
    logic         code_ready;
    logic         data_out;
    logic         bit_valid;
    logic         bit_last;

    // Model: cycles until the block is free again, plus the exact per-cycle output expected.
    int   busy = 0;
    exp_t exp_q[$];

    code_serializer #(.WIDTH(W), .GAP(GP)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_in    (code_in),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .data_out   (data_out),
      .bit_valid  (bit_valid),
      .bit_last   (bit_last)
    );

    function automatic void push_word(input logic [W-1:0] c);
      for (int i = 0; i < W; i++) begin
        exp_t e;
`ifdef CODE_SER_LSB_FIRST_EN
        e.d = c[i];
`else
        e.d = c[W-1-i];
`endif
        e.v = 1'b1;
        e.l = (i == W - 1);
        exp_q.push_back(e);
      end
      for (int i = 0; i < GP; i++) exp_q.push_back('0);
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input logic v, input logic [W-1:0] c, input logic r);
      logic acc;
      rst_n      = r;
      code_valid = v;
      code_in    = c;
      if (!r) exp_q.delete();
      #1;
      check($sformatf("gap%0d code_ready", GP), code_ready, r && (busy <= 1));
      acc = r && v && (busy <= 1);
      if (acc) push_word(c);
      @(posedge clk);
      if (!r)          busy = 0;
      else if (acc)    busy = W + GP;
      else if (busy > 0) busy--;
      @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] c);
      while (busy > 1) drive(1'b1, c, 1'b1);
      drive(1'b1, c, 1'b1);
    endtask

    task automatic idle(input int n);
      repeat (n) drive(1'b0, W'($urandom), 1'b1);
    endtask

    initial begin : stim
      @(negedge clk);
      drive(1'b0, '0, 1'b0);
      drive(1'b0, '0, 1'b0);
      idle(2);
      send(4'b1011);
      idle(W + GP + 2);
      send(4'b1011);
      drive(1'b1, 4'b0110, 1'b1);
      idle(W + GP + 2);
      send(4'b1011);
      send(4'b0110);
      idle(W + GP + 2);
      send(4'b1011);
      idle(1);
      drive(1'b0, '0, 1'b0);
      drive(1'b0, '0, 1'b1);
      send(4'b1100);
      idle(W + GP + 2);
      for (int k = 0; k < 400; k++)
        drive(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 63) != 0);
      idle(W + GP + 2);
      done[g] = 1'b1;
    end

    initial begin : mon
      exp_t e;
      forever begin
        @(posedge clk);
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check($sformatf("gap%0d data_out", GP), data_out, e.d);
        check($sformatf("gap%0d bit_valid", GP), bit_valid, e.v);
        check($sformatf("gap%0d bit_last", GP), bit_last, e.l);
      end
    end
  end

  initial begin
    fork
      begin
        wait (done[0] && done[1]);
      end
      begin
        #500000;
        $display("FAIL timeout: stimulus did not complete");
        bad++;
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
